// File: rtl/alu_share_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : alu_share_arbiter                                        |
// | Description : Shares one external 32-bit ALU between two requesters.   |
// |               Round-robin grant, registered operands, IDLE/EXEC/RESP   |
// |               sequencing and a per-requester valid/ready response.     |
// |               Optional macro ALU_ARB_STATS_EN adds saturating grant    |
// |               counters grant_cnt_0/grant_cnt_1.                        |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module alu_share_arbiter #(
   parameter int WIDTH = 32
`ifdef ALU_ARB_STATS_EN
   ,parameter int CNT_W = 16
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid_0,
   output logic             req_ready_0,
   input  logic [3:0]       req_op_0,
   input  logic [WIDTH-1:0] req_a_0,
   input  logic [WIDTH-1:0] req_b_0,
   input  logic             req_valid_1,
   output logic             req_ready_1,
   input  logic [3:0]       req_op_1,
   input  logic [WIDTH-1:0] req_a_1,
   input  logic [WIDTH-1:0] req_b_1,
   output logic             rsp_valid_0,
   output logic             rsp_valid_1,
   input  logic             rsp_ready_0,
   input  logic             rsp_ready_1,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_err,
`ifdef ALU_ARB_STATS_EN
   output logic [CNT_W-1:0] grant_cnt_0,
   output logic [CNT_W-1:0] grant_cnt_1,
`endif
   output logic [3:0]       alu_sel,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             last_grant_q;
   logic             gnt_q;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] rsp_result_q;
   logic             rsp_zero_q, rsp_err_q;
   logic             rsp_valid_0_q, rsp_valid_1_q;

   logic             w_has_req;
   logic             w_gnt;
   logic             w_accept;
   logic             w_rsp_hs;
   logic             w_op_err;

   // On contention the requester that did not win last time gets the ALU.
   assign w_has_req = req_valid_0 | req_valid_1;
   assign w_gnt     = (req_valid_0 && req_valid_1) ? ~last_grant_q : req_valid_1;
   assign w_accept  = (state_q == S_IDLE) && w_has_req;
   assign w_rsp_hs  = (state_q == S_RESP) && (gnt_q ? rsp_ready_1 : rsp_ready_0);
   assign w_op_err  = (op_q == 4'd0) || (op_q > 4'd13);

   // The ALU always sees the captured operands, so its inputs only move on a grant.
   assign alu_sel     = op_q;
   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign rsp_result  = rsp_result_q;
   assign rsp_zero    = rsp_zero_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_valid_0 = rsp_valid_0_q;
   assign rsp_valid_1 = rsp_valid_1_q;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: one cycle to execute, then wait for the consumer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (w_has_req) state_d = S_EXEC;
         S_EXEC:  state_d = S_RESP;
         S_RESP:  if (w_rsp_hs) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: accept handshake is combinational in IDLE; held low during reset.
   always_comb begin
      req_ready_0 = 1'b0;
      req_ready_1 = 1'b0;
      if (w_accept && !reset) begin
         req_ready_0 = ~w_gnt;
         req_ready_1 = w_gnt;
      end
   end

   // Operand capture, result capture and round-robin history.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q  <= 1'b1;
         gnt_q         <= 1'b0;
         op_q          <= 4'd0;
         a_q           <= '0;
         b_q           <= '0;
         rsp_result_q  <= '0;
         rsp_zero_q    <= 1'b0;
         rsp_err_q     <= 1'b0;
         rsp_valid_0_q <= 1'b0;
         rsp_valid_1_q <= 1'b0;
      end else begin
         if (w_accept) begin
            gnt_q <= w_gnt;
            op_q  <= w_gnt ? req_op_1 : req_op_0;
            a_q   <= w_gnt ? req_a_1  : req_a_0;
            b_q   <= w_gnt ? req_b_1  : req_b_0;
         end
         if (state_q == S_EXEC) begin
            rsp_result_q <= alu_result;
            rsp_zero_q   <= alu_zero;
            rsp_err_q    <= w_op_err;
            if (gnt_q) rsp_valid_1_q <= 1'b1;
            else       rsp_valid_0_q <= 1'b1;
         end
         if (w_rsp_hs) begin
            rsp_valid_0_q <= 1'b0;
            rsp_valid_1_q <= 1'b0;
            last_grant_q  <= gnt_q;
         end
      end
   end

`ifdef ALU_ARB_STATS_EN
   logic [CNT_W-1:0] grant_cnt_0_q, grant_cnt_1_q;

   assign grant_cnt_0 = grant_cnt_0_q;
   assign grant_cnt_1 = grant_cnt_1_q;

   // Saturating per-requester grant counters, bumped on every accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_cnt_0_q <= '0;
         grant_cnt_1_q <= '0;
      end else if (w_accept) begin
         if (!w_gnt && (grant_cnt_0_q != '1)) grant_cnt_0_q <= grant_cnt_0_q + 1'b1;
         if ( w_gnt && (grant_cnt_1_q != '1)) grant_cnt_1_q <= grant_cnt_1_q + 1'b1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_alu_share_arbiter                                     |
// | Description : Directed scoreboard bench for alu_share_arbiter, with a  |
// |               behavioural ALU attached to the alu_* ports.             |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_alu_share_arbiter;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             req_valid_0 = 1'b0, req_valid_1 = 1'b0;
   logic             req_ready_0, req_ready_1;
   logic [3:0]       req_op_0 = 4'd0, req_op_1 = 4'd0;
   logic [WIDTH-1:0] req_a_0 = '0, req_b_0 = '0, req_a_1 = '0, req_b_1 = '0;
   logic             rsp_valid_0, rsp_valid_1;
   logic             rsp_ready_0 = 1'b0, rsp_ready_1 = 1'b0;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_zero, rsp_err;
   logic [3:0]       alu_sel;
   logic [WIDTH-1:0] alu_a, alu_b;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;
`ifdef ALU_ARB_STATS_EN
   logic [15:0]      grant_cnt_0, grant_cnt_1;
`endif

   int n_checks = 0;
   int n_fails  = 0;

   typedef struct {
      logic        g;
      logic [31:0] res;
      logic        z;
      logic        e;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   alu_share_arbiter #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset),
      .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_op_0(req_op_0),
      .req_a_0(req_a_0), .req_b_0(req_b_0),
      .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_op_1(req_op_1),
      .req_a_1(req_a_1), .req_b_1(req_b_1),
      .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
      .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
`ifdef ALU_ARB_STATS_EN
      .grant_cnt_0(grant_cnt_0), .grant_cnt_1(grant_cnt_1),
`endif
      .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_zero(alu_zero)
   );

   // Behavioural ALU: legal codes 1..13, anything else yields zero.
   function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      case (op)
         4'd1:    return a + b;
         4'd2:    return a - b;
         4'd3:    return a & b;
         4'd4:    return a | b;
         4'd5:    return a ^ b;
         4'd6:    return {31'b0, ($signed(a) < $signed(b))};
         4'd7:    return a << b[4:0];
         4'd8:    return a >> b[4:0];
         4'd9:    return ~(a | b);
         4'd10:   return b;
         4'd11:   return a;
         4'd12:   return {31'b0, (a < b)};
         4'd13:   return a + 32'd1;
         default: return 32'd0;
      endcase
   endfunction

   always_comb begin
      alu_result = alu_model(alu_sel, alu_a, alu_b);
      alu_zero   = (alu_result == 32'd0);
   end

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic g, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
      exp_t e;
      e.g   = g;
      e.res = alu_model(op, a, b);
      e.z   = (e.res == 32'd0);
      e.e   = (op == 4'd0) || (op > 4'd13);
      sb.push_back(e);
   endtask

   // Compare the presented response against the oldest scoreboard entry.
   task automatic check_rsp();
      exp_t e;
      check1("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check1("rsp_valid_gnt",   e.g ? rsp_valid_1 : rsp_valid_0, 1'b1);
         check1("rsp_valid_other", e.g ? rsp_valid_0 : rsp_valid_1, 1'b0);
         check32("rsp_result", rsp_result, e.res);
         check1("rsp_zero", rsp_zero, e.z);
         check1("rsp_err", rsp_err, e.e);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check1({tag, "_rsp_valid_0"}, rsp_valid_0, 1'b0);
      check1({tag, "_rsp_valid_1"}, rsp_valid_1, 1'b0);
      check1({tag, "_req_ready_0"}, req_ready_0, 1'b0);
      check1({tag, "_req_ready_1"}, req_ready_1, 1'b0);
      check32({tag, "_rsp_result"}, rsp_result, 32'd0);
      check1({tag, "_rsp_zero"}, rsp_zero, 1'b0);
      check1({tag, "_rsp_err"}, rsp_err, 1'b0);
      check32({tag, "_alu_sel"}, {28'd0, alu_sel}, 32'd0);
      check32({tag, "_alu_a"}, alu_a, 32'd0);
      check32({tag, "_alu_b"}, alu_b, 32'd0);
   endtask

   // One isolated operation from requester r with exact latency checks.
   task automatic single_op(input logic r, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b);
      if (r) begin
         req_valid_1 = 1'b1; req_op_1 = op; req_a_1 = a; req_b_1 = b;
      end else begin
         req_valid_0 = 1'b1; req_op_0 = op; req_a_0 = a; req_b_0 = b;
      end
      #1;
      check1("req_ready_gnt",   r ? req_ready_1 : req_ready_0, 1'b1);
      check1("req_ready_other", r ? req_ready_0 : req_ready_1, 1'b0);
      push_exp(r, op, a, b);
      tick();
      req_valid_0 = 1'b0;
      req_valid_1 = 1'b0;
      check1("rsp_valid_in_exec", rsp_valid_0 | rsp_valid_1, 1'b0);
      check32("alu_sel", {28'd0, alu_sel}, {28'd0, op});
      check32("alu_a", alu_a, a);
      check32("alu_b", alu_b, b);
      tick();
      check_rsp();
      if (r) rsp_ready_1 = 1'b1; else rsp_ready_0 = 1'b1;
      tick();
      rsp_ready_0 = 1'b0;
      rsp_ready_1 = 1'b0;
      check1("rsp_valid_cleared", rsp_valid_0 | rsp_valid_1, 1'b0);
   endtask

   initial begin
      logic g;

      // Reset state
      tick();
      tick();
      check_reset_vals("reset");
      reset = 1'b0;
      tick();
      check1("idle_no_req", req_ready_0 | req_ready_1, 1'b0);

      // Single operations, including illegal and boundary op codes
      single_op(1'b0, 4'd1, 32'd5, 32'd7);
      single_op(1'b1, 4'd2, 32'd9, 32'd9);
      single_op(1'b0, 4'd15, 32'd3, 32'd4);
      single_op(1'b1, 4'd0, 32'd3, 32'd4);
      single_op(1'b0, 4'd13, 32'd6, 32'd2);
      single_op(1'b1, 4'd14, 32'd1, 32'd1);

      // Both requesters valid continuously: strict alternation from req0
      reset = 1'b1;
      tick();
      reset = 1'b0;
`ifdef ALU_ARB_STATS_EN
      check32("cnt0_after_reset", {16'd0, grant_cnt_0}, 32'd0);
      check32("cnt1_after_reset", {16'd0, grant_cnt_1}, 32'd0);
`endif
      req_valid_0 = 1'b1; req_op_0 = 4'd1;
      req_valid_1 = 1'b1; req_op_1 = 4'd2;
      rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         req_a_0 = $urandom; req_b_0 = $urandom;
         req_a_1 = $urandom; req_b_1 = $urandom;
         #1;
         g = k[0];
         check1("rr_ready_0", req_ready_0, ~g);
         check1("rr_ready_1", req_ready_1, g);
         push_exp(g, g ? req_op_1 : req_op_0, g ? req_a_1 : req_a_0, g ? req_b_1 : req_b_0);
         tick();
         check1("rr_ready_busy", req_ready_0 | req_ready_1, 1'b0);
         tick();
         check_rsp();
         tick();
      end
      req_valid_0 = 1'b0; req_valid_1 = 1'b0;
      rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
`ifdef ALU_ARB_STATS_EN
      check32("cnt0_after_four", {16'd0, grant_cnt_0}, 32'd2);
      check32("cnt1_after_four", {16'd0, grant_cnt_1}, 32'd2);
`endif

      // Consumer back-pressure on req0 while req1 waits
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req_valid_0 = 1'b1; req_op_0 = 4'd1; req_a_0 = 32'd100; req_b_0 = 32'd23;
      req_valid_1 = 1'b1; req_op_1 = 4'd4; req_a_1 = 32'hF0; req_b_1 = 32'h0F;
      #1;
      check1("hold_ready_0", req_ready_0, 1'b1);
      push_exp(1'b0, 4'd1, 32'd100, 32'd23);
      tick();
      req_valid_0 = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         check1("hold_rsp_valid_0", rsp_valid_0, 1'b1);
         check32("hold_result", rsp_result, 32'd123);
         check1("hold_no_grant", req_ready_0 | req_ready_1, 1'b0);
         tick();
      end
      check_rsp();
      rsp_ready_0 = 1'b1;
      tick();
      rsp_ready_0 = 1'b0;
      check1("after_hold_ready_1", req_ready_1, 1'b1);
      check1("after_hold_ready_0", req_ready_0, 1'b0);
      push_exp(1'b1, 4'd4, 32'hF0, 32'h0F);
      tick();
      req_valid_1 = 1'b0;
      tick();
      check_rsp();
      rsp_ready_1 = 1'b1;
      tick();
      rsp_ready_1 = 1'b0;

      // Reset while in EXEC abandons the op and restores req0 priority
      single_op(1'b0, 4'd3, 32'hFF, 32'h0F);
      req_valid_0 = 1'b1; req_op_0 = 4'd1; req_a_0 = 32'd40; req_b_0 = 32'd2;
      req_valid_1 = 1'b1; req_op_1 = 4'd2; req_a_1 = 32'd50; req_b_1 = 32'd8;
      #1;
      check1("pre_reset_ready_1", req_ready_1, 1'b1);
      tick();
      reset = 1'b1;
      tick();
      check_reset_vals("midreset");
      reset = 1'b0;
      #1;
      check1("post_reset_ready_0", req_ready_0, 1'b1);
      check1("post_reset_ready_1", req_ready_1, 1'b0);
      push_exp(1'b0, 4'd1, 32'd40, 32'd2);
      tick();
      req_valid_0 = 1'b0; req_valid_1 = 1'b0;
      tick();
      check_rsp();
      rsp_ready_0 = 1'b1;
      tick();
      rsp_ready_0 = 1'b0;
      check1("final_idle", rsp_valid_0 | rsp_valid_1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
